// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU request port and memory handshake port of the data cache controller.
// Latency: signal bundle only; no storage.
// Backpressure: CPU side holds a request until Ready_Cache; memory side holds Req_Mem until Ready_Mem.
// Ports (slave = cache side):
//   CPU    : Req_CPU, Wr_CPU, A_CPU, D_CPU, Ins_Type -> cache; Ready_Cache, D_Cache <- cache
//   Memory : Req_Mem, Wr_Mem, A_Mem, D_Mem_out <- cache; D_Mem_in, Ready_Mem -> cache
//   Stats  : hit_cnt, miss_cnt <- cache
interface cache_ctrl_if;
    logic        Req_CPU;
    logic        Wr_CPU;
    logic [31:0] A_CPU;
    logic [31:0] D_CPU;
    logic [1:0]  Ins_Type;
    logic        Ready_Cache;
    logic [31:0] D_Cache;
    logic        Req_Mem;
    logic        Wr_Mem;
    logic [31:0] A_Mem;
    logic [31:0] D_Mem_out;
    logic [31:0] D_Mem_in;
    logic        Ready_Mem;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  Req_CPU, Wr_CPU, A_CPU, D_CPU, Ins_Type, D_Mem_in, Ready_Mem,
        output Ready_Cache, D_Cache, Req_Mem, Wr_Mem, A_Mem, D_Mem_out, hit_cnt, miss_cnt
    );

    modport master (
        output Req_CPU, Wr_CPU, A_CPU, D_CPU, Ins_Type, D_Mem_in, Ready_Mem,
        input  Ready_Cache, D_Cache, Req_Mem, Wr_Mem, A_Mem, D_Mem_out, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate data cache, one 32-bit word per line.
// Latency: hit -> Ready_Cache two cycles after the request is sampled; misses add write-back/fill phases.
// Backpressure: one transaction at a time; new requests accepted only in IDLE, memory waits on Ready_Mem.
// Ports: clk, rst (synchronous, active-high); bus (cache_ctrl_if.slave) carries the CPU request/response
// and memory request/response signals plus hit_cnt/miss_cnt.
// Optional feature: define CACHE_STATS_EN to build the hit/miss counters; otherwise they read 0.
module cache_ctrl #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    cache_ctrl_if.slave bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 32 - INDEX_W - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRBACK, FILL, RESP} state_t;
    state_t state_q, state_d;

    // Latched CPU request
    logic        wr_q,   wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [1:0]  size_q, size_d;

    // Line storage
    logic [31:0]      data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q, dirty_q;

    // Registered outputs
    logic        ready_q,    ready_d;
    logic [31:0] dcache_q,   dcache_d;
    logic        req_mem_q,  req_mem_d;
    logic        wr_mem_q,   wr_mem_d;
    logic [31:0] a_mem_q,    a_mem_d;
    logic [31:0] dmem_out_q, dmem_out_d;

    // Array update strobes
    logic line_we, tag_we, dirty_we, dirty_val;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [31:0]        base, merged, result;

    function automatic logic [31:0] merge_store(input logic [31:0] line, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        m = line;
        case (sz)
            2'b01:   if (off[1]) m[31:16] = wd[15:0]; else m[15:0] = wd[15:0];
            2'b10:   m[{off, 3'b000} +: 8] = wd[7:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] select_lane(input logic [31:0] line, input logic [1:0] sz,
                                                input logic [1:0] off);
        logic [31:0] lane;
        case (sz)
            2'b01:   lane = {16'h0000, off[1] ? line[31:16] : line[15:0]};
            2'b10:   lane = {24'h000000, line[{off, 3'b000} +: 8]};
            default: lane = line;
        endcase
        return lane;
    endfunction

    assign idx = addr_q[INDEX_W+1:2];
    assign tag = addr_q[31:INDEX_W+2];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    // During FILL the access works on the incoming memory word, so the fill and the
    // CPU access (including a store merge) complete on the same edge.
    assign base   = (state_q == FILL) ? bus.D_Mem_in : data_q[idx];
    assign merged = wr_q ? merge_store(base, wdat_q, size_q, addr_q[1:0]) : base;
    assign result = select_lane(merged, size_q, addr_q[1:0]);

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        size_d     = size_q;
        ready_d    = 1'b0;
        dcache_d   = dcache_q;
        req_mem_d  = req_mem_q;
        wr_mem_d   = wr_mem_q;
        a_mem_d    = a_mem_q;
        dmem_out_d = dmem_out_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        dirty_we   = 1'b0;
        dirty_val  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Req_CPU) begin
                    wr_d    = bus.Wr_CPU;
                    addr_d  = bus.A_CPU;
                    wdat_d  = bus.D_CPU;
                    size_d  = bus.Ins_Type;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    line_we   = wr_q;
                    dirty_we  = wr_q;
                    dirty_val = 1'b1;
                    dcache_d  = result;
                    ready_d   = 1'b1;
                    state_d   = RESP;
                end else begin
                    req_mem_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        wr_mem_d   = 1'b1;
                        a_mem_d    = {tag_q[idx], idx, 2'b00};
                        dmem_out_d = data_q[idx];
                        state_d    = WRBACK;
                    end else begin
                        wr_mem_d = 1'b0;
                        a_mem_d  = {addr_q[31:2], 2'b00};
                        state_d  = FILL;
                    end
                end
            end
            WRBACK: begin
                if (bus.Ready_Mem) begin
                    req_mem_d = 1'b0;
                    dirty_we  = 1'b1;
                    dirty_val = 1'b0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                // Arriving from WRBACK, Req_Mem is low for one cycle before the fill request.
                if (!req_mem_q) begin
                    req_mem_d = 1'b1;
                    wr_mem_d  = 1'b0;
                    a_mem_d   = {addr_q[31:2], 2'b00};
                end else if (bus.Ready_Mem) begin
                    req_mem_d = 1'b0;
                    line_we   = 1'b1;
                    tag_we    = 1'b1;
                    dirty_we  = 1'b1;
                    dirty_val = wr_q;
                    dcache_d  = result;
                    ready_d   = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
            size_q     <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            ready_q    <= 1'b0;
            dcache_q   <= '0;
            req_mem_q  <= 1'b0;
            wr_mem_q   <= 1'b0;
            a_mem_q    <= '0;
            dmem_out_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            size_q     <= size_d;
            ready_q    <= ready_d;
            dcache_q   <= dcache_d;
            req_mem_q  <= req_mem_d;
            wr_mem_q   <= wr_mem_d;
            a_mem_q    <= a_mem_d;
            dmem_out_q <= dmem_out_d;
            if (tag_we)   valid_q[idx] <= 1'b1;
            if (dirty_we) dirty_q[idx] <= dirty_val;
        end
    end

    // Data and tags need no reset: valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (line_we) data_q[idx] <= merged;
        if (tag_we)  tag_q[idx]  <= tag;
    end

    assign bus.Ready_Cache = ready_q;
    assign bus.D_Cache     = dcache_q;
    assign bus.Req_Mem     = req_mem_q;
    assign bus.Wr_Mem      = wr_mem_q;
    assign bus.A_Mem       = a_mem_q;
    assign bus.D_Mem_out   = dmem_out_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl with a word-level reference memory model.
// Latency: hit responses expected two cycles after the request is sampled.
// Backpressure: memory responder stalls a random 0-3 cycles per request.
module tb_cache_ctrl;
    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if bus();
    cache_ctrl #(.INDEX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } memop_t;

    memop_t      exp_ops[$];           // expected memory requests, in order
    logic [31:0] exp_q[$];             // expected D_Cache per response
    logic [31:0] bk[int unsigned];     // backing memory, word keyed
    logic [31:0] arch[int unsigned];   // architectural (CPU-visible) memory, word keyed
    logic [31:0] mline[64];
    bit          mvalid[64];
    bit          mdirty[64];
    int unsigned m_hits, m_misses;
    logic [31:0] last_dcache;
    logic [31:0] last_wb_addr, last_wb_data;
    bit          mem_stall = 1'b0;

    function automatic logic [31:0] bk_read(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (bk.exists(k)) return bk[k];
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] arch_read(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (arch.exists(k)) return arch[k];
        return bk_read(a);
    endfunction

    function automatic int unsigned acc_off(input logic [31:0] a, input logic [1:0] t);
        if (t == 2'b10) return int'(a[1:0]);
        if (t == 2'b01) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] t);
        if (t == 2'b10) return 32'h0000_00FF;
        if (t == 2'b01) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        arch.delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Issue one CPU access, predicting its response and memory traffic first.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int unsigned idx, off;
        logic [31:0] la, w, m;
        bit          hit;
        int          n;
        idx = (a >> 2) % 64;
        la  = {a[31:2], 2'b00};
        hit = mvalid[idx] && (mline[idx] == la);
        if (hit) m_hits++;
        else begin
            m_misses++;
            if (mvalid[idx] && mdirty[idx])
                exp_ops.push_back('{1'b1, mline[idx], arch_read(mline[idx])});
            exp_ops.push_back('{1'b0, la, 32'h0});
            mline[idx]  = la;
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
        end
        w   = arch_read(la);
        off = acc_off(a, t);
        m   = lane_mask(t);
        if (wr) begin
            w = (w & ~(m << (8 * off))) | ((d & m) << (8 * off));
            arch[la >> 2] = w;
            mdirty[idx] = 1'b1;
        end
        exp_q.push_back((w >> (8 * off)) & m);

        bus.Req_CPU  = 1'b1;
        bus.Wr_CPU   = wr;
        bus.A_CPU    = a;
        bus.D_CPU    = d;
        bus.Ins_Type = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.Ready_Cache && n < 200);
        if (!bus.Ready_Cache) fail_now("resp_timeout");
        else if (hit) check("hit_latency", n, 2);
        bus.Req_CPU  = 1'b0;
        bus.Wr_CPU   = 1'($urandom_range(0, 1));
        bus.A_CPU    = $urandom;
        bus.D_CPU    = $urandom;
        bus.Ins_Type = 2'($urandom_range(0, 3));
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Response monitor: pops one expectation per Ready_Cache pulse.
    always @(negedge clk) begin
        if (!rst && bus.Ready_Cache) begin
            if (exp_q.size() == 0) fail_now("unexpected_resp");
            else check("load_data", bus.D_Cache, exp_q.pop_front());
            last_dcache = bus.D_Cache;
        end
    end

    // Memory responder and memory-side checker.
    bit     mbusy = 1'b0;
    memop_t cur, e;
    int     mdelay;
    always @(negedge clk) begin
        if (rst) begin
            mbusy         = 1'b0;
            bus.Ready_Mem = 1'b0;
        end else if (bus.Ready_Mem) begin
            bus.Ready_Mem = 1'b0;
            check("mem_req_drop", bus.Req_Mem, 1'b0);
            check("resp_after_mem", bus.Ready_Cache, cur.wr ? 1'b0 : 1'b1);
            mbusy = 1'b0;
        end else if (mbusy) begin
            check("mem_addr_stable", bus.A_Mem, cur.addr);
            check("mem_wr_stable", bus.Wr_Mem, cur.wr);
            if (!mem_stall) begin
                if (mdelay == 0) begin
                    bus.Ready_Mem = 1'b1;
                    bus.D_Mem_in  = cur.wr ? $urandom : bk_read(cur.addr);
                    if (cur.wr) bk[cur.addr >> 2] = cur.data;
                end else mdelay--;
            end
        end else if (bus.Req_Mem) begin
            cur    = '{bus.Wr_Mem, bus.A_Mem, bus.D_Mem_out};
            mbusy  = 1'b1;
            mdelay = $urandom_range(0, 3);
            if (cur.wr) begin
                last_wb_addr = cur.addr;
                last_wb_data = cur.data;
            end
            if (exp_ops.size() == 0) fail_now("unexpected_mem_req");
            else begin
                e = exp_ops.pop_front();
                check("mem_wr", cur.wr, e.wr);
                check("mem_addr", cur.addr, e.addr);
                if (e.wr) check("wb_data", cur.data, e.data);
            end
        end
        if (!bus.Ready_Mem) bus.D_Mem_in = $urandom;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        rst          = 1'b1;
        bus.Req_CPU  = 1'b0;
        bus.Wr_CPU   = 1'b0;
        bus.A_CPU    = '0;
        bus.D_CPU    = '0;
        bus.Ins_Type = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", bus.Ready_Cache, 1'b0);
        check("rst_dcache", bus.D_Cache, 32'h0);
        check("rst_req_mem", bus.Req_Mem, 1'b0);
        check("rst_wr_mem", bus.Wr_Mem, 1'b0);
        check("rst_a_mem", bus.A_Mem, 32'h0);
        check("rst_d_mem_out", bus.D_Mem_out, 32'h0);
        check("rst_hit_cnt", bus.hit_cnt, 32'h0);
        check("rst_miss_cnt", bus.miss_cnt, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed sequence
        bk[32'h100 >> 2] = 32'hDEADBEEF;
        do_access(1'b0, 32'h100, 32'h0, 2'b00);
        check("tp_fill_data", last_dcache, 32'hDEADBEEF);
        do_access(1'b0, 32'h100, 32'h0, 2'b00);
        do_access(1'b1, 32'h101, 32'h0000_00AB, 2'b10);
        do_access(1'b0, 32'h100, 32'h0, 2'b00);
        check("tp_store_merge", last_dcache, 32'hDEADABEF);
        do_access(1'b0, 32'h102, 32'h0, 2'b01);
        check("tp_half_load", last_dcache, 32'h0000DEAD);
        do_access(1'b0, 32'h103, 32'h0, 2'b10);
        check("tp_byte_load", last_dcache, 32'h000000DE);
        do_access(1'b0, 32'h200, 32'h0, 2'b00);
        check("tp_wb_addr", last_wb_addr, 32'h100);
        check("tp_wb_data", last_wb_data, 32'hDEADABEF);
        do_access(1'b1, 32'h100, 32'h1122_3344, 2'b00);

        // Reset while a fill is outstanding
        mem_stall = 1'b1;
        exp_ops.push_back('{1'b0, 32'h140, 32'h0});
        bus.Req_CPU  = 1'b1;
        bus.Wr_CPU   = 1'b0;
        bus.A_CPU    = 32'h140;
        bus.Ins_Type = 2'b00;
        n = 0;
        while (!bus.Req_Mem && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.Req_Mem) fail_now("rst_setup_timeout");
        bus.Req_CPU = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_mem", bus.Req_Mem, 1'b0);
        check("midrst_ready", bus.Ready_Cache, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        mem_stall = 1'b0;
        check("midrst_fill_issued", exp_ops.size(), 0);
        exp_ops.delete();
        model_reset();
        check("midrst_hit_cnt", bus.hit_cnt, 32'h0);
        @(negedge clk);

        // Dirty 0x11223344 was lost; the line refills from memory. Then three hits.
        do_access(1'b0, 32'h100, 32'h0, 2'b00);
        check("tp_dirty_discarded", last_dcache, 32'hDEADABEF);
        for (int i = 0; i < 3; i++) do_access(1'b0, 32'h100, 32'h0, 2'b00);
        check("stats_hit", bus.hit_cnt, STATS ? 32'd3 : 32'd0);
        check("stats_miss", bus.miss_cnt, STATS ? 32'd1 : 32'd0);

        // Random traffic over a few tags and indices to force conflicts
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            do_access(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)));
        end
        repeat (4) @(negedge clk);
        check("final_hit_cnt", bus.hit_cnt, STATS ? m_hits : 32'd0);
        check("final_miss_cnt", bus.miss_cnt, STATS ? m_misses : 32'd0);
        check("resp_queue_drained", exp_q.size(), 0);
        check("mem_queue_drained", exp_ops.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back, write-allocate data cache controller that answers the CPU request port (Req_CPU/Wr_CPU/A_CPU/Ins_Type/write data) and returns Ready_Cache plus read data. It sits between the CPU core and main memory, holding one 32-bit word per line, and drives a simple request/ready handshake toward memory for fills and dirty evictions. Byte, halfword and word accesses are supported via Ins_Type.

## Interface
Parameters:
- INDEX_W, 6, index bits; 2^INDEX_W lines; index = A[INDEX_W+1:2], tag = A[31:INDEX_W+2]

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- Req_CPU  in  1  CPU request; held with all request fields stable until Ready_Cache sampled high
- Wr_CPU  in  1  1 = store, 0 = load
- A_CPU  in  32  byte address
- D_CPU  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- Ins_Type  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word
- Ready_Cache  out  1  one-cycle completion pulse
- D_Cache  out  32  load data, zero-extended, right-aligned; valid while Ready_Cache high
- Req_Mem  out  1  memory request
- Wr_Mem  out  1  1 = write-back, 0 = fill read
- A_Mem  out  32  word-aligned memory address (A[1:0]=00)
- D_Mem_out  out  32  write-back data
- D_Mem_in  in  32  fill data, sampled when Ready_Mem high
- Ready_Mem  in  1  memory completion, one cycle
- hit_cnt  out  32  hit counter (see Configuration)
- miss_cnt  out  32  miss counter (see Configuration)

## Operation
- Arrays: data[2^INDEX_W] x32, tag, valid, dirty; valid/dirty are flop vectors cleared by rst.
- States: IDLE, LOOKUP, WRBACK, FILL, RESP.
- IDLE: Req_CPU sampled high -> latch Wr, A, D, Ins_Type; -> LOOKUP. No acceptance in RESP.
- LOOKUP: hit = valid[idx] && tag match. Hit -> perform access, -> RESP. Miss & dirty -> WRBACK. Miss & clean/invalid -> FILL.
- WRBACK: Req_Mem=1, Wr_Mem=1, A_Mem={old tag, idx, 00}, D_Mem_out=old data; on Ready_Mem -> FILL, dirty cleared.
- FILL: Req_Mem=1, Wr_Mem=0, A_Mem={A[31:2],00}; on Ready_Mem write D_Mem_in to line, set valid, tag; then perform the access in the same edge (merge for store), -> RESP.
- Access: load selects lane: halfword A[1]? [31:16]:[15:0]; byte lane A[1:0]; A[0] ignored for halfword. Store merges only the selected byte lanes, sets dirty.
- RESP: Ready_Cache=1, D_Cache valid (stores return merged word's selected lane); -> IDLE.
- Req_CPU dropping before Ready_Cache is a protocol violation; the transaction completes regardless.
- Ready_Mem outside WRBACK/FILL is ignored.

## Timing
- Reset values: Ready_Cache 0, D_Cache 0, Req_Mem 0, Wr_Mem 0, A_Mem 0, D_Mem_out 0, counters 0, state IDLE, all valid/dirty 0.
- Hit: Req_CPU sampled at edge N -> Ready_Cache high in cycle N+2, low N+3. Back-to-back hits: one per 3 cycles.
- Miss clean: Req_Mem rises in cycle N+2; Ready_Mem sampled at edge M -> Req_Mem low and Ready_Cache high in cycle M+1.
- Miss dirty: write-back phase precedes fill; Req_Mem low for exactly one cycle between phases.
- Memory fields stable whenever Req_Mem high.
- rst mid-operation: next cycle state IDLE, Req_Mem 0, Ready_Cache 0; in-flight transaction and dirty data discarded.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- CACHE_STATS_EN defined: hit_cnt increments on each LOOKUP hit, miss_cnt on each LOOKUP miss; 32-bit, wrap at 2^32; cleared by rst.
- Not defined: counter logic omitted, hit_cnt and miss_cnt tied to 0; ports remain.

## Test plan
- Reset, load word 0x100, memory returns 0xDEADBEEF -> Req_Mem read A_Mem=0x100, Ready_Cache with D_Cache=0xDEADBEEF; repeat load -> Ready_Cache at N+2, no Req_Mem.
- Store byte 0xAB (Ins_Type=10) to 0x101, then load word 0x100 -> D_Cache=0xDEADABEF, no memory traffic.
- Load 0x200 (index 0, new tag) after dirty line -> write-back Wr_Mem=1 A_Mem=0x100 D_Mem_out=0xDEADABEF, then fill A_Mem=0x200.
- Halfword load 0x102 on line 0xDEADABEF -> D_Cache=0x0000DEAD; byte load 0x103 -> 0x000000DE.
- rst asserted during FILL with Req_Mem high -> Req_Mem 0 next cycle; subsequent load 0x100 misses.
- CACHE_STATS_EN: sequence of 1 miss, 3 hits -> hit_cnt=3, miss_cnt=1; without macro both read 0.
